// File: rtl/hdc_assoc_search.sv
// rtl/hdc_assoc_search.sv - HDC associative search: Hamming distance of a query to HAM/SPAM classes
module hdc_assoc_search #(
    parameter int DIM   = 1024,
    parameter int CHUNK = 64,
    parameter int DW    = $clog2(DIM + 1)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [DIM-1:0] query_hv,
    input  logic [DIM-1:0] ham_hv,
    input  logic [DIM-1:0] spam_hv,
    input  logic           label,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [1:0]     result,
    output logic [DW-1:0]  dist_ham,
    output logic [DW-1:0]  dist_spam,
    output logic           match
);
    localparam int NCHUNK = DIM / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t          state, state_nxt;
    logic [DIM-1:0]  q_sh, h_sh, s_sh;
    logic            label_r;
    logic [CW-1:0]   cnt;
    logic [DW-1:0]   acc_h, acc_s, sum_h, sum_s;
    logic            last;
    logic [1:0]      res_nxt;
    logic            match_nxt;

    function automatic logic [DW-1:0] popcnt(input logic [CHUNK-1:0] v);
        logic [DW-1:0] c;
        c = '0;
        for (int i = 0; i < CHUNK; i++) c = c + DW'(v[i]);
        return c;
    endfunction

    // Running sums including the chunk currently at the bottom of the shifters
    always_comb begin
        sum_h     = acc_h + popcnt(q_sh[CHUNK-1:0] ^ h_sh[CHUNK-1:0]);
        sum_s     = acc_s + popcnt(q_sh[CHUNK-1:0] ^ s_sh[CHUNK-1:0]);
        last      = (cnt == CW'(NCHUNK - 1));
        res_nxt   = (sum_h < sum_s) ? 2'b01 : (sum_s < sum_h) ? 2'b10 : 2'b11;
        match_nxt = ((res_nxt == 2'b01) && !label_r) || ((res_nxt == 2'b10) && label_r);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = SCAN;
            SCAN:    if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    assign in_ready = (state == IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_sh      <= '0;
            h_sh      <= '0;
            s_sh      <= '0;
            label_r   <= 1'b0;
            cnt       <= '0;
            acc_h     <= '0;
            acc_s     <= '0;
            out_valid <= 1'b0;
            result    <= 2'b00;
            dist_ham  <= '0;
            dist_spam <= '0;
            match     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        q_sh    <= query_hv;
                        h_sh    <= ham_hv;
                        s_sh    <= spam_hv;
                        label_r <= label;
                        acc_h   <= '0;
                        acc_s   <= '0;
                        cnt     <= '0;
                    end
                end
                SCAN: begin
                    acc_h <= sum_h;
                    acc_s <= sum_s;
                    q_sh  <= q_sh >> CHUNK;
                    h_sh  <= h_sh >> CHUNK;
                    s_sh  <= s_sh >> CHUNK;
                    cnt   <= last ? '0 : cnt + CW'(1);
                    if (last) begin
                        dist_ham  <= sum_h;
                        dist_spam <= sum_s;
                        result    <= res_nxt;
                        match     <= match_nxt;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_hdc_assoc_search.sv
// tb/tb_hdc_assoc_search.sv - directed vector bench for hdc_assoc_search
module tb_hdc_assoc_search;
    localparam int DIM = 1024;
    localparam int DW  = 11;

    typedef struct {
        logic [DIM-1:0] q;
        logic [DIM-1:0] h;
        logic [DIM-1:0] s;
        logic           label;
        int             dh;
        int             ds;
        logic [1:0]     res;
        logic           m;
    } vec_t;

    logic           clk = 1'b0;
    logic           reset;
    logic           in_valid;
    logic           in_ready;
    logic [DIM-1:0] query_hv, ham_hv, spam_hv;
    logic           label;
    logic           out_valid;
    logic           out_ready;
    logic [1:0]     result;
    logic [DW-1:0]  dist_ham, dist_spam;
    logic           match;

    int n_cmp = 0;
    int n_bad = 0;

    hdc_assoc_search #(.DIM(DIM), .CHUNK(64)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .query_hv(query_hv), .ham_hv(ham_hv), .spam_hv(spam_hv), .label(label),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .dist_ham(dist_ham), .dist_spam(dist_spam), .match(match)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the acceptance edge
    task automatic accept(input vec_t v, output int waited);
        waited = 0;
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        chk("accept_timeout", 64'(waited < 200), 64'd1);
        query_hv = v.q;
        ham_hv   = v.h;
        spam_hv  = v.s;
        label    = v.label;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic chk_result(input string tag, input vec_t v);
        chk({tag, "_dist_ham"}, 64'(dist_ham), 64'(v.dh));
        chk({tag, "_dist_spam"}, 64'(dist_spam), 64'(v.ds));
        chk({tag, "_result"}, 64'(result), 64'(v.res));
        chk({tag, "_match"}, 64'(match), 64'(v.m));
    endtask

    vec_t           vecs[5];
    logic [DIM-1:0] r, mask;

    initial begin
        int lat, waited, unstable;
        logic [1:0]    sv_res;
        logic [DW-1:0] sv_dh, sv_ds;
        logic          sv_m;

        for (int i = 0; i < DIM / 32; i++) r[i*32 +: 32] = $urandom;
        mask = (1024'd1 << 100) - 1'b1;

        vecs[0] = '{q: r, h: r, s: ~r, label: 1'b0, dh: 0, ds: 1024, res: 2'b01, m: 1'b1};
        vecs[1] = '{q: r, h: r ^ mask, s: r, label: 1'b0, dh: 100, ds: 0, res: 2'b10, m: 1'b0};
        vecs[2] = '{q: '0, h: '0, s: '0, label: 1'b1, dh: 1, ds: 1, res: 2'b11, m: 1'b0};
        vecs[2].h[1023] = 1'b1;
        vecs[2].s[0]    = 1'b1;
        vecs[3] = '{q: '0, h: (1024'd1 << 512) - 1'b1, s: (1024'd1 << 600) - 1'b1,
                    label: 1'b0, dh: 512, ds: 600, res: 2'b01, m: 1'b1};
        vecs[4] = '{q: r, h: r, s: r, label: 1'b1, dh: 4, ds: 3, res: 2'b10, m: 1'b1};
        vecs[4].h[1023] = ~r[1023];
        vecs[4].h[2:0]  = ~r[2:0];
        vecs[4].s[66:64] = ~r[66:64];

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; label = 1'b0;
        query_hv = '0; ham_hv = '0; spam_hv = '0;
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_dist_ham", 64'(dist_ham), 64'd0);
        chk("rst_dist_spam", 64'(dist_spam), 64'd0);
        chk("rst_match", 64'(match), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            accept(vecs[i], waited);
            chk($sformatf("v%0d_in_ready_busy", i), 64'(in_ready), 64'd0);
            wait_out(lat);
            chk($sformatf("v%0d_latency", i), 64'(lat), 64'd16);
            chk_result($sformatf("v%0d", i), vecs[i]);
            @(negedge clk);
            chk($sformatf("v%0d_post_out_valid", i), 64'(out_valid), 64'd0);
            chk($sformatf("v%0d_post_in_ready", i), 64'(in_ready), 64'd1);
            chk($sformatf("v%0d_held_dist_ham", i), 64'(dist_ham), 64'(vecs[i].dh));
        end

        // Backpressure: hold 20 cycles, stray in_valid pulse must be dropped
        out_ready = 1'b0;
        accept(vecs[0], waited);
        wait_out(lat);
        chk("bp_latency", 64'(lat), 64'd16);
        chk_result("bp", vecs[0]);
        sv_res = result; sv_dh = dist_ham; sv_ds = dist_spam; sv_m = match;
        unstable = 0;
        for (int c = 0; c < 20; c++) begin
            if (c == 5) begin
                query_hv = vecs[2].q; ham_hv = vecs[2].h; spam_hv = vecs[2].s;
                label = vecs[2].label; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== sv_res ||
                dist_ham !== sv_dh || dist_spam !== sv_ds || match !== sv_m)
                unstable++;
        end
        chk("bp_unstable_cycles", 64'(unstable), 64'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_release_out_valid", 64'(out_valid), 64'd0);
        chk("bp_release_in_ready", 64'(in_ready), 64'd1);
        chk("bp_release_result_held", 64'(result), 64'(vecs[0].res));
        wait_out(lat);
        chk("bp_no_queued_bundle", 64'(lat), 64'd100);

        // Reset mid-scan; previous result (dist_spam=1024) must vanish at once
        out_ready = 1'b1;
        accept(vecs[0], waited);
        repeat (5) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_result", 64'(result), 64'd0);
        chk("mid_rst_dist_ham", 64'(dist_ham), 64'd0);
        chk("mid_rst_dist_spam", 64'(dist_spam), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        accept(vecs[1], waited);
        wait_out(lat);
        chk("after_rst_latency", 64'(lat), 64'd16);
        chk_result("after_rst", vecs[1]);
        @(negedge clk);

        // Back-to-back with out_ready tied high
        accept(vecs[3], waited);
        wait_out(lat);
        chk("b2b_a_latency", 64'(lat), 64'd16);
        chk_result("b2b_a", vecs[3]);
        accept(vecs[4], waited);
        chk("b2b_gap_cycles", 64'(waited + 1), 64'd2);
        wait_out(lat);
        chk("b2b_b_latency", 64'(lat), 64'd16);
        chk_result("b2b_b", vecs[4]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/hdc_assoc_search.md
Name: hdc_assoc_search

Overview:
- Associative-memory search stage downstream of the message encoder in the HDC spam/ham classifier.
- Accepts one DIM-bit query hypervector, plus the HAM and SPAM class hypervectors and the expected tag.
- Computes the Hamming distance to both classes, CHUNK bits per cycle.
- Emits the 2-bit classification, which drives the top-level result, together with both distances and a label-match flag for the bench.

Parameters:
- DIM, 1024: hypervector dimension in bits. Must be a multiple of CHUNK.
- CHUNK, 64: bits compared per cycle. NCHUNK = DIM/CHUNK.
- DW, $clog2(DIM+1): distance width. Default 11.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  query/class/label bundle valid.
- in_ready  out  1  block can accept a bundle.
- query_hv  in  DIM  encoded message hypervector.
- ham_hv  in  DIM  HAM class hypervector.
- spam_hv  in  DIM  SPAM class hypervector.
- label  in  1  expected tag: 0 = ham, 1 = spam.
- out_valid  out  1  result valid. Held until accepted.
- out_ready  in  1  consumer accepts the result.
- result  out  2  00 = none, 01 = ham, 10 = spam, 11 = tie.
- dist_ham  out  DW  Hamming distance from query to ham_hv.
- dist_spam  out  DW  Hamming distance from query to spam_hv.
- match  out  1  result agrees with label.

Behaviour:
- Reset (async, active-high): state IDLE. in_ready=1 in IDLE. out_valid=0, result=00, dist_ham=0, dist_spam=0, match=0. Internal accumulators, chunk counter and shift registers are all cleared.
- FSM states: IDLE, SCAN, DONE.
- IDLE: in_ready=1. On a rising edge with in_valid=1:
  - Latch query_hv, ham_hv, spam_hv and label into internal registers.
  - Clear both accumulators; chunk counter = 0.
  - Go to SCAN.
  - Input ports are not sampled again until the next IDLE acceptance.
- SCAN: in_ready=0. Each cycle:
  - Take the low CHUNK bits of each latched vector.
  - acc_h += popcount(q ^ h); acc_s += popcount(q ^ s). Popcount is CHUNK-bit, zero-extended to DW; no overflow is possible.
  - Shift the latched vectors right by CHUNK; increment the counter.
  - Chunk k (bits k*CHUNK+CHUNK-1 .. k*CHUNK) is processed on the (k+1)th SCAN edge.
- Final chunk: on the edge that processes chunk NCHUNK-1:
  - dist_ham and dist_spam take the final sums (including this chunk).
  - result is set: 01 if dist_ham<dist_spam, 10 if dist_spam<dist_ham, 11 if equal.
  - match is set: (result==01 & label==0) | (result==10 & label==1). A tie gives match=0.
  - out_valid goes to 1; state goes to DONE.
- Latency: acceptance edge E0; out_valid is high after edge E(NCHUNK). Default = 16 cycles after acceptance.
- DONE: in_ready=0. out_valid, result, distances and match are held stable while out_ready=0.
  - On an edge with out_ready=1: out_valid goes to 0 and state goes to IDLE. result, distances and match keep their values until the next final-chunk edge.
  - A new bundle can be accepted at the earliest one cycle after the DONE→IDLE edge.
- in_valid during SCAN or DONE is ignored; no queuing.
- out_ready outside DONE has no effect.
- Reset asserted mid-SCAN or in DONE aborts immediately to reset values; the partial result is discarded.
- Counter wrap: the counter runs 0..NCHUNK-1 only. No state beyond that is reachable.
- All outputs are registered; there is no combinational path from inputs to outputs except in_ready, which decodes the state only.

Test Plan:
- Exact match: query=ham_hv=random R, spam_hv=~R, label=0, out_ready=1 → out_valid rises 16 cycles after acceptance; dist_ham=0, dist_spam=1024, result=01, match=1.
- Spam with mismatched tag: query=spam_hv=R, ham_hv=R^(low 100 bits set), label=0 → dist_ham=100, dist_spam=0, result=10, match=0.
- Tie and top chunk coverage:
  - query=0, ham_hv has bit 1023 set only, spam_hv has bit 0 set only, label=1 → dist_ham=1, dist_spam=1, result=11, match=0.
  - Confirms the first and last chunks are both counted.
- Backpressure: out_ready=0 for 20 cycles after out_valid → all outputs stable, in_ready=0, and a new in_valid pulse is ignored. Then out_ready=1 for one cycle → out_valid=0, in_ready=1 on the next cycle.
- Reset mid-scan: assert reset 5 cycles after acceptance → immediately out_valid=0, result=00, dist_*=0, in_ready=1. Then a fresh bundle completes in 16 cycles with correct distances.
- Back-to-back: two bundles, each presented as soon as in_ready=1, with out_ready tied to 1 → two results. The second acceptance is no earlier than 2 cycles after the first out_valid rise; both results are correct.
